// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding, parity helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        MAB
    } tx_state_e;

    // The word is zero-padded to 9 bits, so unused upper bits do not affect the result.
    function automatic logic parity_bit(input logic [8:0] word, input int mode);
        return (mode == PARITY_ODD) ? ~(^word) : ^word;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side word handshake for the UART transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (output tx_valid, tx_data, input tx_ready, tx_busy, tx_done);
    modport slave  (input tx_valid, tx_data, output tx_ready, tx_busy, tx_done);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: held at CLKS_PER_BIT-1 while reload is high, otherwise
// counts down and wraps, pulsing tick on the last clock of each bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic reload,
    output logic tick,
    output logic tick_early
);
    localparam int            CW  = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TOP = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload || cnt_q == '0) begin
            cnt_d = TOP;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick       = !reload && (cnt_q == '0);
    // One clock ahead of tick; lets a caller end a period one clock early.
    assign tick_early = !reload && (cnt_q == CW'(1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity, 1-2 stop bits.
// Optional line-break generation when UART_TX_BREAK_EN is defined.
//   state  | meaning
//   IDLE   | line high, ready for a word (also the final clock of the stop period)
//   START  | start bit (0)
//   DATA   | data bits, LSB first
//   PARITY | parity bit
//   STOP   | stop bit(s), minus the final clock
//   BREAK  | line held low while tx_break is high
//   MAB    | mark-after-break, one bit period high
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = PARITY_EVEN,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_frame_if.slave        tx_if,
`ifdef UART_TX_BREAK_EN
    input  logic                  tx_break,
`endif
    output logic                  tx_serial
);
    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
        PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
        $fatal(1, "uart_tx_frame: illegal parameter value");
    end

    localparam int            BW        = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic                 serial_q, serial_d;
    logic                 done_q, done_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 stop_q, stop_d;

    logic       ready, accept, baud_hold, tick, tick_early;
    logic [8:0] word;

`ifdef UART_TX_BREAK_EN
    assign ready = (state_q == IDLE) && !tx_break;
`else
    assign ready = (state_q == IDLE);
`endif
    assign accept    = tx_if.tx_valid && ready;
    assign baud_hold = (state_q == IDLE) || (state_q == BREAK);

    always_comb begin
        word = '0;
        word[DATA_BITS-1:0] = tx_if.tx_data;
    end

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk        (clk),
        .rst_n      (rst_n),
        .reload     (baud_hold),
        .tick       (tick),
        .tick_early (tick_early)
    );

    always_comb begin
        state_d  = state_q;
        serial_d = serial_q;
        done_d   = 1'b0;
        shift_d  = shift_q;
        par_d    = par_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        case (state_q)
            IDLE: begin
`ifdef UART_TX_BREAK_EN
                if (tx_break) begin
                    state_d  = BREAK;
                    serial_d = 1'b0;
                end else
`endif
                if (accept) begin
                    state_d  = START;
                    serial_d = 1'b0;
                    shift_d  = tx_if.tx_data;
                    par_d    = parity_bit(word, PARITY_MODE);
                    bit_d    = '0;
                    stop_d   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_d  = DATA;
                    serial_d = shift_q[0];
                    shift_d  = shift_q >> 1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        if (PARITY_MODE != PARITY_NONE) begin
                            state_d  = PARITY;
                            serial_d = par_q;
                        end else begin
                            state_d  = STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        bit_d    = bit_q + 1'b1;
                        serial_d = shift_q[0];
                        shift_d  = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d  = STOP;
                    serial_d = 1'b1;
                end
            end
            STOP: begin
                // The done/IDLE clock is the last clock of the stop period, so a
                // back-to-back word starts with no extra idle clock.
                if (stop_q == STOP_LAST && tick_early) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tick) begin
                    stop_d = 1'b1;
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                if (!tx_break) begin
                    state_d  = MAB;
                    serial_d = 1'b1;
                end
            end
            MAB: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            serial_q <= serial_d;
            done_q   <= done_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
        end
    end

    assign tx_if.tx_ready = ready;
    assign tx_if.tx_busy  = !ready;
    assign tx_if.tx_done  = done_q;
    assign tx_serial      = serial_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: three configurations with CLKS_PER_BIT = 4.
module tb_uart_tx_frame;
    localparam int CPB = 4;

    logic       clk;
    logic       rst_n;
    logic [2:0] vld;
    logic [8:0] dat [3];
    logic [2:0] ser, done, rdy, busy;
    int         tests_run;
    int         tests_failed;

    uart_tx_frame_if #(.DATA_BITS(8)) u_if0 ();
    uart_tx_frame_if #(.DATA_BITS(8)) u_if1 ();
    uart_tx_frame_if #(.DATA_BITS(7)) u_if2 ();

`ifdef UART_TX_BREAK_EN
    logic brk;
    initial brk = 1'b0;
`endif

    assign u_if0.tx_valid = vld[0];
    assign u_if1.tx_valid = vld[1];
    assign u_if2.tx_valid = vld[2];
    assign u_if0.tx_data  = dat[0][7:0];
    assign u_if1.tx_data  = dat[1][7:0];
    assign u_if2.tx_data  = dat[2][6:0];
    assign done = {u_if2.tx_done,  u_if1.tx_done,  u_if0.tx_done};
    assign rdy  = {u_if2.tx_ready, u_if1.tx_ready, u_if0.tx_ready};
    assign busy = {u_if2.tx_busy,  u_if1.tx_busy,  u_if0.tx_busy};

    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_if(u_if0),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx_serial(ser[0]));

    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_if(u_if1),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx_serial(ser[1]));

    uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_if(u_if2),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx_serial(ser[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if (ser[d] !== 1'b1 || rdy[d] !== 1'b1 || busy[d] !== 1'b0 || done[d] !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset dut%0d: ser=%b rdy=%b busy=%b done=%b, want 1 1 0 0",
                         d, ser[d], rdy[d], busy[d], done[d]);
            end
        end
    endtask

    // fr holds the expected line, bit k = k-th transmitted bit (start at bit 0).
    task automatic send_frame(input int d, input logic [8:0] data, input logic [15:0] fr,
                              input int nbits, input string name);
        int last;
        last = nbits * CPB - 1;
        @(negedge clk);
        tests_run++;
        if (rdy[d] !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s ready_before: got %b want 1", name, rdy[d]);
        end
        vld[d] = 1'b1;
        dat[d] = data;
        @(negedge clk);
        vld[d] = 1'b0;
        dat[d] = ~data;
        for (int k = 0; k <= last; k++) begin
            if (k > 0) @(negedge clk);
            tests_run++;
            if (ser[d] !== fr[k / CPB]) begin
                tests_failed++;
                $display("FAIL %s serial clk %0d: got %b want %b", name, k, ser[d], fr[k / CPB]);
            end
            tests_run++;
            if (done[d] !== (k == last) || busy[d] !== (k != last)) begin
                tests_failed++;
                $display("FAIL %s done/busy clk %0d: got %b/%b want %b/%b", name, k,
                         done[d], busy[d], k == last, k != last);
            end
        end
        @(negedge clk);
        tests_run++;
        if (done[d] !== 1'b0 || ser[d] !== 1'b1 || rdy[d] !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s after: done=%b ser=%b rdy=%b want 0 1 1", name, done[d], ser[d], rdy[d]);
        end
    endtask

    task automatic test_base_frame();
        send_frame(0, 9'h0A5, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, "base_even_a5");
    endtask

    task automatic test_parity();
        send_frame(1, 9'h000, 16'({1'b1, 1'b1, 8'h00, 1'b0}), 11, "odd_00");
        send_frame(1, 9'h0A5, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, "odd_a5");
        send_frame(0, 9'h0FF, 16'({1'b1, 1'b0, 8'hFF, 1'b0}), 11, "even_ff");
    endtask

    task automatic test_framing_variant();
        send_frame(2, 9'h041, 16'({2'b11, 7'h41, 1'b0}), 10, "np2s_41");
    endtask

    task automatic test_back_to_back();
        logic [21:0] fr;
        int          n_done;
        fr     = {1'b1, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0};
        n_done = 0;
        @(negedge clk);
        vld[0] = 1'b1;
        dat[0] = 9'h055;
        @(negedge clk);
        dat[0] = 9'h0AA;
        for (int k = 0; k < 90; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 44) vld[0] = 1'b0;
            if (done[0] === 1'b1) n_done++;
            if (k < 88) begin
                tests_run++;
                if (ser[0] !== fr[k / CPB]) begin
                    tests_failed++;
                    $display("FAIL b2b serial clk %0d: got %b want %b", k, ser[0], fr[k / CPB]);
                end
            end
            if (k == 43 || k == 87) begin
                tests_run++;
                if (done[0] !== 1'b1 || rdy[0] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL b2b done clk %0d: done=%b rdy=%b want 1 1", k, done[0], rdy[0]);
                end
            end
        end
        tests_run++;
        if (n_done != 2) begin
            tests_failed++;
            $display("FAIL b2b done_count: got %0d want 2", n_done);
        end
    endtask

    task automatic test_reset_mid_frame();
        int n_done;
        n_done = 0;
        @(negedge clk);
        vld[0] = 1'b1;
        dat[0] = 9'h000;
        @(negedge clk);
        vld[0] = 1'b0;
        // Clock 17 after acceptance lies inside data bit 3 (clocks 16..19).
        repeat (17) @(negedge clk);
        tests_run++;
        if (ser[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid pre: ser got %b want 0", ser[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (ser[0] !== 1'b1 || rdy[0] !== 1'b1 || done[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid async: ser=%b rdy=%b done=%b want 1 1 0", ser[0], rdy[0], done[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done[0] === 1'b1 || ser[0] !== 1'b1) n_done++;
        end
        tests_run++;
        if (n_done != 0) begin
            tests_failed++;
            $display("FAIL rst_mid after: %0d clocks with done or low line, want 0", n_done);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        vld          = '0;
        for (int i = 0; i < 3; i++) dat[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_base_frame();
        test_parity();
        test_framing_variant();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
